// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle ALU.
//   master : drives start, ctrl, num1, num2; observes busy, ans, error, e_message, done
//   slave  : the ALU side of the same signals
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic [WIDTH-1:0] ans;
    logic             error;
    logic [1:0]       e_message;
    logic             done;

    modport master (
        output start, ctrl, num1, num2,
        input  busy, ans, error, e_message, done
    );

    modport slave (
        input  start, ctrl, num1, num2,
        output busy, ans, error, e_message, done
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: small multi-cycle ALU (LUI, ADDI, ADD, SLL) with error reporting.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_mc_if.slave: start/ctrl/num1/num2 in; busy/ans/error/e_message/done out
// Single-cycle ops complete with done one cycle after acceptance. SLL by N>0
// shifts one bit per cycle and completes N+1 cycles after acceptance.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; operands and ctrl sampled on accept
// S_SHIFT | SLL in progress, accumulator shifts once per cycle
// S_DONE  | done pulse; results valid; returns to S_IDLE next cycle
module alu_mc #(
    parameter int WIDTH       = 32,
    parameter int IMM_W       = 16,
    parameter int ALIGN_CHECK = 1
) (
    input logic   clk,
    input logic   rst,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_LUI  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc;

    logic [SHW-1:0]          shamt;
    logic signed [IMM_W-1:0] imm_s;
    logic [WIDTH-1:0]        imm_ext;
    logic [WIDTH-1:0]        sum_add;
    logic [WIDTH-1:0]        sum_addi;
    logic [WIDTH-1:0]        lui_val;
    logic                    ovf_add;
    logic                    ovf_addi;
    logic                    misal;

    always_comb begin
        shamt    = bus.num1[SHW-1:0];
        imm_s    = signed'(bus.num2[IMM_W-1:0]);
        imm_ext  = WIDTH'(imm_s);
        sum_add  = bus.num1 + bus.num2;
        sum_addi = bus.num1 + imm_ext;
        // Shifting the whole operand left drops everything above the immediate field.
        lui_val  = bus.num2 << (WIDTH - IMM_W);
        ovf_add  = (bus.num1[WIDTH-1] == bus.num2[WIDTH-1]) &&
                   (sum_add[WIDTH-1] != bus.num1[WIDTH-1]);
        ovf_addi = (bus.num1[WIDTH-1] == imm_ext[WIDTH-1]) &&
                   (sum_addi[WIDTH-1] != bus.num1[WIDTH-1]);
        misal    = (ALIGN_CHECK != 0) && (sum_addi[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            acc           <= '0;
            bus.ans       <= '0;
            bus.error     <= 1'b0;
            bus.e_message <= 2'd0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                        case (bus.ctrl)
                            OP_LUI: begin
                                bus.ans       <= lui_val;
                                bus.e_message <= 2'd0;
                                bus.error     <= 1'b0;
                            end
                            OP_ADDI: begin
                                bus.ans <= sum_addi;
                                // Overflow outranks misalignment.
                                if (ovf_addi) begin
                                    bus.e_message <= 2'd1;
                                    bus.error     <= 1'b1;
                                end else if (misal) begin
                                    bus.e_message <= 2'd2;
                                    bus.error     <= 1'b1;
                                end else begin
                                    bus.e_message <= 2'd0;
                                    bus.error     <= 1'b0;
                                end
                            end
                            OP_ADD: begin
                                bus.ans       <= sum_add;
                                bus.e_message <= ovf_add ? 2'd1 : 2'd0;
                                bus.error     <= ovf_add;
                            end
                            OP_SLL: begin
                                if (shamt == '0) begin
                                    bus.ans       <= bus.num2;
                                    bus.e_message <= 2'd0;
                                    bus.error     <= 1'b0;
                                end else begin
                                    // Results stay untouched until the last shift.
                                    acc      <= bus.num2;
                                    cnt      <= shamt;
                                    state    <= S_SHIFT;
                                    bus.done <= 1'b0;
                                end
                            end
                            default: begin
                                bus.ans       <= '0;
                                bus.e_message <= 2'd3;
                                bus.error     <= 1'b1;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    acc <= acc << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        bus.ans       <= acc << 1;
                        bus.e_message <= 2'd0;
                        bus.error     <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 8..64.
REQ-002 Parameter IMM_W, default 16, immediate field width; SHALL be at most WIDTH.
REQ-003 Parameter ALIGN_CHECK, default 1, enables word-alignment checking of ADDI results.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-007 ctrl  input  4  one-hot opcode: 0001 LUI, 0010 ADDI, 0100 ADD, 1000 SLL.
REQ-008 num1  input  WIDTH  operand rs; for SLL, bits [log2(WIDTH)-1:0] are the shift amount.
REQ-009 num2  input  WIDTH  operand rt or immediate; for SLL, the value to shift.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 ans  output  WIDTH  registered result.
REQ-012 error  output  1  registered; high when e_message is nonzero.
REQ-013 e_message  output  2  registered: 0 ok, 1 signed overflow, 2 misaligned address, 3 illegal ctrl.
REQ-014 done  output  1  single-cycle pulse marking ans, error and e_message valid.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 IDLE with start=1: latch ctrl, num1 and num2 on that edge and leave IDLE; start=0 keeps IDLE.
REQ-017 start SHALL be ignored in SHIFT and DONE; an ignored start has no side effects.
REQ-018 LUI: ans = {num2[IMM_W-1:0], (WIDTH-IMM_W) zeros}; error=0.
REQ-019 ADDI: ans = num1 + sign-extended num2[IMM_W-1:0], wrapped to WIDTH bits.
REQ-020 ADD: ans = num1 + num2, wrapped to WIDTH bits.
REQ-021 ADD and ADDI signed overflow (operands same sign, result sign differs) SHALL set e_message=1; ans keeps the wrapped sum.
REQ-022 ADDI with ALIGN_CHECK=1, no overflow and ans[1:0]!=0 SHALL set e_message=2; overflow takes precedence over misalignment.
REQ-023 Any ctrl other than the four one-hot codes: ans=0, e_message=3.
REQ-024 LUI, ADDI, ADD, illegal ctrl and SLL with shift amount 0: IDLE->DONE; done asserted on the cycle after the accepting edge (latency 1).
REQ-025 SLL with shift amount N>0: IDLE->SHIFT; an accumulator loaded with num2 shifts left one bit per cycle and a counter loaded with N decrements.
REQ-026 SLL in SHIFT: after the Nth shift, go to DONE; done is high N+1 cycles after the accepting edge; ans = num2 << N with bits shifted out dropped; e_message=0.
REQ-027 DONE SHALL last exactly one cycle, then go to IDLE; a new start is accepted the following cycle, so operations issue no more often than every two cycles.
REQ-028 ans, error and e_message SHALL hold their values from DONE until the next DONE; they SHALL NOT change during SHIFT.
REQ-029 Operand or ctrl changes after the accepting edge SHALL NOT affect the result in flight.

Reset
REQ-030 While rst=1: state=IDLE, counter=0, accumulator=0, ans=0, error=0, e_message=0, done=0, busy=0.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL abort the operation immediately; no done pulse follows.
REQ-032 The first start accepted is the one sampled on the first rising edge after rst deasserts.

Verification
REQ-033 ADD, num1=0x7FFFFFFF, num2=0x00000001 -> one cycle later: done=1, ans=0x80000000, error=1, e_message=1.
REQ-034 LUI, num2=0x00001234 -> one cycle later: done=1, ans=0x12340000, error=0; ans still 0x12340000 three cycles later.
REQ-035 SLL, num1=4, num2=0x00000001 -> busy high for 5 cycles, done on the 5th cycle after start, ans=0x00000010; a start pulsed mid-shift is ignored.
REQ-036 ADDI, num1=0x00001000, num2=0x0000FFFE -> ans=0x00000FFE, e_message=2; same case with ALIGN_CHECK=0 -> e_message=0.
REQ-037 ctrl=0011 -> ans=0, error=1, e_message=3; then SLL with num1=31, rst pulsed at cycle 10 -> outputs zero, no done, busy=0.
REQ-038 WIDTH=16, IMM_W=8: ADD num1=0x7FFF, num2=0x0001 -> ans=0x8000, e_message=1; SLL num1=15, num2=1 -> ans=0x8000 after 16 cycles.
